// File: rtl/digital_input_capture.sv
// digital_input_capture
//
// Samples external pins through a flip-flop synchroniser, detects rising and
// falling edges on the synchronised level and latches masked edge events
// into a sticky, write-1-to-clear PENDING register.  The interrupt request is
// the OR of all pending bits.
//
// Registers (single-cycle access, chipSelect qualifies writeEnable):
//   address 0 LEVEL      read-only, current synchronised (or debounced) level
//   address 1 RISE_MASK  read/write, enables rising-edge events per pin
//   address 2 FALL_MASK  read/write, enables falling-edge events per pin
//   address 3 PENDING    read, write-1-to-clear
//
// Ports:
//   clk          system clock, all state on rising edge
//   reset        synchronous, active-high reset
//   chipSelect   bus select
//   writeEnable  write strobe (ignored without chipSelect)
//   address      register select
//   dataIn       write data
//   dataOut      read data, combinational from address, 0 when not selected
//   IO_IN        asynchronous external pins
//   interrupt    OR-reduction of PENDING
//
// Build option:
//   DIGITAL_INPUT_DEBOUNCE_EN  when defined, each pin passes through a
//   tick-based debouncer after the synchroniser.  A shared prescaler emits a
//   tick every DEBOUNCE_DIV clocks; a pin must disagree with its debounced
//   value for DEBOUNCE_COUNT ticks before the new value is accepted.
//   When undefined, LEVEL is the last synchroniser stage.

module digital_input_capture #(
  parameter int WIDTH          = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_DIV   = 1000,
  parameter int DEBOUNCE_COUNT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipSelect,
  input  logic             writeEnable,
  input  logic [1:0]       address,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  input  logic [WIDTH-1:0] IO_IN,
  output logic             interrupt
);

  // Elaboration-time parameter sanity checks.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("digital_input_capture: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_DIV < 1) begin : g_bad_div
    $error("digital_input_capture: DEBOUNCE_DIV must be at least 1");
  end
  if (DEBOUNCE_COUNT < 1) begin : g_bad_count
    $error("digital_input_capture: DEBOUNCE_COUNT must be at least 1");
  end

  localparam logic [1:0] ADDR_LEVEL = 2'd0;
  localparam logic [1:0] ADDR_RISE  = 2'd1;
  localparam logic [1:0] ADDR_FALL  = 2'd2;
  localparam logic [1:0] ADDR_PEND  = 2'd3;

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;

  always_comb begin
    sync_d[0] = IO_IN;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Level source: debounced or raw synchronised
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] level;

`ifdef DIGITAL_INPUT_DEBOUNCE_EN
  localparam int PRE_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_COUNT + 1);

  logic [PRE_W-1:0] prescale_q;
  logic [PRE_W-1:0] prescale_d;
  logic             tick;
  logic [CNT_W-1:0] deb_cnt_q [WIDTH];
  logic [CNT_W-1:0] deb_cnt_d [WIDTH];
  logic [WIDTH-1:0] debounced_q;
  logic [WIDTH-1:0] debounced_d;

  always_comb begin
    tick        = (prescale_q == PRE_W'(DEBOUNCE_DIV - 1));
    prescale_d  = tick ? '0 : prescale_q + 1'b1;
    debounced_d = debounced_q;
    for (int i = 0; i < WIDTH; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (sync_out[i] == debounced_q[i]) begin
        // Agreement at any moment restarts the qualification window, which
        // is what rejects short glitches.
        deb_cnt_d[i] = '0;
      end else if (tick) begin
        if (deb_cnt_q[i] + 1'b1 == CNT_W'(DEBOUNCE_COUNT)) begin
          debounced_d[i] = sync_out[i];
          deb_cnt_d[i]   = '0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_q  <= '0;
      debounced_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      prescale_q  <= prescale_d;
      debounced_q <= debounced_d;
      for (int i = 0; i < WIDTH; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  assign level = debounced_q;
`else
  assign level = sync_out;
`endif

  // ---------------------------------------------------------------------------
  // Edge detection, masks and pending register
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] level_prev_q, level_prev_d;
  logic [WIDTH-1:0] rise_mask_q, rise_mask_d;
  logic [WIDTH-1:0] fall_mask_q, fall_mask_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] rise, fall, clr;
  logic             bus_wr;

  always_comb begin
    bus_wr       = chipSelect & writeEnable;
    rise         = level & ~level_prev_q;
    fall         = ~level & level_prev_q;
    clr          = (bus_wr && address == ADDR_PEND) ? dataIn : '0;
    // New events are OR-ed in after the clear so a simultaneous set wins.
    pending_d    = (pending_q & ~clr) | (rise & rise_mask_q) | (fall & fall_mask_q);
    rise_mask_d  = (bus_wr && address == ADDR_RISE) ? dataIn : rise_mask_q;
    fall_mask_d  = (bus_wr && address == ADDR_FALL) ? dataIn : fall_mask_q;
    level_prev_d = level;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_prev_q <= '0;
      rise_mask_q  <= '0;
      fall_mask_q  <= '0;
      pending_q    <= '0;
    end else begin
      level_prev_q <= level_prev_d;
      rise_mask_q  <= rise_mask_d;
      fall_mask_q  <= fall_mask_d;
      pending_q    <= pending_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and interrupt
  // ---------------------------------------------------------------------------
  always_comb begin
    dataOut = '0;
    if (chipSelect) begin
      case (address)
        ADDR_LEVEL: dataOut = level;
        ADDR_RISE:  dataOut = rise_mask_q;
        ADDR_FALL:  dataOut = fall_mask_q;
        default:    dataOut = pending_q;
      endcase
    end
  end

  assign interrupt = |pending_q;

endmodule

// File: tb/tb_digital_input_capture.sv
module tb_digital_input_capture;

  localparam int W  = 32;
  localparam int SS = 2;
`ifdef DIGITAL_INPUT_DEBOUNCE_EN
  localparam int DDIV = 4;
  localparam int DCNT = 3;
`else
  localparam int DDIV = 1000;
  localparam int DCNT = 3;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         chipSelect = 1'b0;
  logic         writeEnable = 1'b0;
  logic [1:0]   address = 2'd0;
  logic [W-1:0] dataIn = '0;
  logic [W-1:0] dataOut;
  logic [W-1:0] IO_IN = '0;
  logic         interrupt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  digital_input_capture #(
    .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_DIV(DDIV), .DEBOUNCE_COUNT(DCNT)
  ) dut (
    .clk(clk), .reset(reset), .chipSelect(chipSelect), .writeEnable(writeEnable),
    .address(address), .dataIn(dataIn), .dataOut(dataOut), .IO_IN(IO_IN),
    .interrupt(interrupt)
  );

  // Reference model: the pin history as sampled at each clock edge, plus the
  // architectural registers.  LEVEL is simply the pin value sampled SS-1
  // edges ago; edges are differences between consecutive history entries.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;
  logic [W-1:0] m_pend;

  function automatic logic [W-1:0] model_level(input int back);
    return hist[hist.size() - SS - back];
  endfunction

  function automatic logic [W-1:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return model_level(0);
      2'd1:    return m_rise;
      2'd2:    return m_fall;
      default: return m_pend;
    endcase
  endfunction

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic step();
    logic [W-1:0] lvl, prv, ev, clr, nr, nf;
    logic wr;
    lvl = model_level(0);
    prv = model_level(1);
    wr  = chipSelect && writeEnable;
    clr = (wr && address == 2'd3) ? dataIn : '0;
    ev  = ((lvl & ~prv) & m_rise) | ((~lvl & prv) & m_fall);
    nr  = (wr && address == 2'd1) ? dataIn : m_rise;
    nf  = (wr && address == 2'd2) ? dataIn : m_fall;
    @(posedge clk);
    if (reset) begin
      hist = {};
      for (int i = 0; i <= SS; i++) hist.push_back('0);
      m_rise = '0;
      m_fall = '0;
      m_pend = '0;
    end else begin
      m_pend = (m_pend & ~clr) | ev;
      m_rise = nr;
      m_fall = nf;
      hist.push_back(IO_IN);
      if (hist.size() > 16) void'(hist.pop_front());
    end
    #1;
  endtask

  task automatic bus_idle();
    chipSelect  = 1'b0;
    writeEnable = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [W-1:0] d);
    chipSelect  = 1'b1;
    writeEnable = 1'b1;
    address     = a;
    dataIn      = d;
    step();
    bus_idle();
  endtask

  task automatic bus_read(input logic [1:0] a);
    chipSelect  = 1'b1;
    writeEnable = 1'b0;
    address     = a;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_idle();
    step();
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a));
      vectors++;
      if (dataOut !== '0) begin
        miscompares++;
        $display("FAIL reset_reg%0d: got %h expected %h", a, dataOut, '0);
      end
    end
    bus_idle();
    #1;
    vectors++;
    if (dataOut !== '0 || interrupt !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: dataOut %h irq %b expected 0 0", dataOut, interrupt);
    end
    IO_IN = 32'hFFFF_FFFF;
    repeat (4) step();
    bus_read(2'd0);
    vectors++;
    if (dataOut !== 32'hFFFF_FFFF || dataOut !== model_read(2'd0)) begin
      miscompares++;
      $display("FAIL level_after_reset: got %h expected %h", dataOut, 32'hFFFF_FFFF);
    end
    bus_read(2'd3);
    vectors++;
    if (dataOut !== '0 || interrupt !== 1'b0) begin
      miscompares++;
      $display("FAIL no_event_after_reset: pending %h irq %b expected 0 0", dataOut, interrupt);
    end
    bus_idle();
  endtask

  task automatic test_edges();
    IO_IN = '0;
    repeat (4) step();
    bus_write(2'd1, 32'h0000_00FF);
    bus_write(2'd2, 32'hFF00_0000);
    IO_IN = 32'h1234_5678;
    for (int e = 1; e <= 3; e++) begin
      step();
      bus_read(2'd3);
      vectors++;
      if (dataOut !== model_read(2'd3) || dataOut !== ((e == 3) ? 32'h78 : 32'h0)) begin
        miscompares++;
        $display("FAIL rise_latency_edge%0d: got %h expected %h", e, dataOut, model_read(2'd3));
      end
    end
    vectors++;
    if (interrupt !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_after_rise: got %b expected 1", interrupt);
    end
    bus_idle();
    IO_IN = '0;
    repeat (3) step();
    bus_read(2'd3);
    vectors++;
    if (dataOut !== 32'h1200_0078) begin
      miscompares++;
      $display("FAIL pending_after_fall: got %h expected %h", dataOut, 32'h1200_0078);
    end
    bus_write(2'd3, 32'h0000_0070);
    bus_read(2'd3);
    vectors++;
    if (dataOut !== 32'h1200_0008 || interrupt !== 1'b1) begin
      miscompares++;
      $display("FAIL w1c_partial: pending %h irq %b expected %h 1", dataOut, interrupt, 32'h1200_0008);
    end
    bus_idle();
  endtask

  task automatic test_set_clear_collision();
    IO_IN = 32'h0000_0008;
    repeat (2) step();
    // The rise of bit 3 is visible now and latches on the next edge,
    // exactly when the clear of bit 3 is written.
    bus_write(2'd3, 32'h0000_0008);
    bus_read(2'd3);
    vectors++;
    if (dataOut !== 32'h1200_0008 || dataOut !== model_read(2'd3)) begin
      miscompares++;
      $display("FAIL set_beats_clear: got %h expected %h", dataOut, 32'h1200_0008);
    end
    bus_write(2'd3, 32'h0000_0008);
    bus_read(2'd3);
    vectors++;
    if (dataOut !== 32'h1200_0000) begin
      miscompares++;
      $display("FAIL clear_alone: got %h expected %h", dataOut, 32'h1200_0000);
    end
    bus_idle();
  endtask

  task automatic test_bus_qualifiers();
    logic [W-1:0] lvl_before;
    chipSelect  = 1'b0;
    writeEnable = 1'b1;
    address     = 2'd1;
    dataIn      = $urandom | 32'h0000_0100;
    step();
    bus_read(2'd1);
    vectors++;
    if (dataOut !== 32'h0000_00FF) begin
      miscompares++;
      $display("FAIL write_without_cs: rise_mask %h expected %h", dataOut, 32'h0000_00FF);
    end
    bus_read(2'd0);
    lvl_before = model_read(2'd0);
    bus_write(2'd0, ~lvl_before);
    bus_read(2'd0);
    vectors++;
    if (dataOut !== lvl_before) begin
      miscompares++;
      $display("FAIL write_level_ignored: level %h expected %h", dataOut, lvl_before);
    end
    bus_idle();
  endtask

  task automatic test_mask_change();
    // Pending bit 25 is latched; removing its mask must not clear it, and
    // enabling rise on an already-high pin must not invent an event.
    bus_write(2'd2, 32'h0000_0000);
    bus_write(2'd1, 32'h0000_0008);
    repeat (3) step();
    bus_read(2'd3);
    vectors++;
    if (dataOut !== 32'h1200_0000 || dataOut !== model_read(2'd3)) begin
      miscompares++;
      $display("FAIL mask_change_sticky: got %h expected %h", dataOut, 32'h1200_0000);
    end
    bus_idle();
  endtask

  task automatic test_reset_mid();
    reset       = 1'b1;
    chipSelect  = 1'b1;
    writeEnable = 1'b1;
    address     = 2'd1;
    dataIn      = 32'hFFFF_FFFF;
    IO_IN       = 32'hA5A5_0000;
    step();
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a));
      vectors++;
      if (dataOut !== '0) begin
        miscompares++;
        $display("FAIL reset_mid_reg%0d: got %h expected %h", a, dataOut, '0);
      end
    end
    vectors++;
    if (interrupt !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_irq: got %b expected 0", interrupt);
    end
    bus_idle();
  endtask

  task automatic test_random();
    logic [W-1:0] exp_d;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) IO_IN = $urandom;
      else if ($urandom_range(0, 1) == 0) IO_IN = IO_IN ^ (32'h1 << $urandom_range(0, 31));
      reset       = ($urandom_range(0, 79) == 0);
      chipSelect  = $urandom_range(0, 1);
      writeEnable = ($urandom_range(0, 2) == 0);
      address     = 2'($urandom_range(0, 3));
      dataIn      = $urandom;
      #1;
      exp_d = chipSelect ? model_read(address) : '0;
      vectors++;
      if (dataOut !== exp_d || interrupt !== (|m_pend)) begin
        miscompares++;
        $display("FAIL random_cycle%0d addr%0d: dataOut %h irq %b expected %h %b",
                 n, address, dataOut, interrupt, exp_d, |m_pend);
      end
      step();
    end
    reset = 1'b0;
    bus_idle();
  endtask

  task automatic test_debounce();
    reset = 1'b1;
    bus_idle();
    IO_IN = '0;
    step();
    reset = 1'b0;
    bus_write(2'd1, 32'h0000_0001);
    repeat (10) step();
    IO_IN = 32'h1;
    repeat (5) step();
    IO_IN = '0;
    repeat (20) step();
    bus_read(2'd0);
    vectors++;
    if (dataOut[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL debounce_glitch_level: got %b expected 0", dataOut[0]);
    end
    bus_read(2'd3);
    vectors++;
    if (dataOut !== '0) begin
      miscompares++;
      $display("FAIL debounce_glitch_pending: got %h expected 0", dataOut);
    end
    bus_idle();
    IO_IN = 32'h1;
    repeat (16) step();
    bus_read(2'd0);
    vectors++;
    if (dataOut[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL debounce_hold_level: got %b expected 1", dataOut[0]);
    end
    step();
    bus_read(2'd3);
    vectors++;
    if (dataOut !== 32'h1 || interrupt !== 1'b1) begin
      miscompares++;
      $display("FAIL debounce_hold_pending: pending %h irq %b expected 1 1", dataOut, interrupt);
    end
    bus_idle();
  endtask

  initial begin
    hist = {};
    for (int i = 0; i <= SS; i++) hist.push_back('0);
    m_rise = '0;
    m_fall = '0;
    m_pend = '0;
`ifdef DIGITAL_INPUT_DEBOUNCE_EN
    test_debounce();
`else
    test_reset();
    test_edges();
    test_set_clear_collision();
    test_bus_qualifiers();
    test_mask_change();
    test_reset_mid();
    test_random();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
